// File: rtl/ret_unstack_fsm.sv
// Return unstack sequencer: pops the saved PC (and the flags for RTI) from the
// data stack as 16-bit words and redirects Fetch to the rebuilt return address.
module ret_unstack_fsm #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 32,
   parameter int FLAG_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_rti,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  pop_req,
   output logic                  busy,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic [FLAG_WIDTH-1:0] flags_out,
   output logic                  redirect,
   output logic                  flags_valid
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      POP_FLAGS = 3'd1,
      POP_HI    = 3'd2,
      POP_LO    = 3'd3,
      WAIT_LO   = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t                state_r;
   state_t                stateNext_s;
   logic                  isRti_r;
   logic                  popReq_r;
   logic                  busy_r;
   logic                  redirect_r;
   logic                  flagsValid_r;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [FLAG_WIDTH-1:0] flags_r;

   function automatic logic isPopState(input state_t s);
      logic result;
      case (s)
         POP_FLAGS, POP_HI, POP_LO: result = 1'b1;
         default:                   result = 1'b0;
      endcase
      return result;
   endfunction

   // Next-state selection; start is only looked at in IDLE.
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               stateNext_s = is_rti ? POP_FLAGS : POP_HI;
            end else begin
               stateNext_s = IDLE;
            end
         end
         POP_FLAGS: stateNext_s = POP_HI;
         POP_HI:    stateNext_s = POP_LO;
         POP_LO:    stateNext_s = WAIT_LO;
         WAIT_LO:   stateNext_s = DONE;
         DONE:      stateNext_s = IDLE;
         default:   stateNext_s = IDLE;
      endcase
   end

   // State register and strobes, decoded from the next state so every output is a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         isRti_r      <= 1'b0;
         popReq_r     <= 1'b0;
         busy_r       <= 1'b0;
         redirect_r   <= 1'b0;
         flagsValid_r <= 1'b0;
      end else begin
         state_r      <= stateNext_s;
         popReq_r     <= isPopState(stateNext_s);
         busy_r       <= (stateNext_s != IDLE);
         redirect_r   <= (stateNext_s == DONE);
         flagsValid_r <= (stateNext_s == DONE) && isRti_r;
         if ((state_r == IDLE) && start) begin
            isRti_r <= is_rti;
         end else begin
            isRti_r <= isRti_r;
         end
      end
   end

   // Word-by-word capture of read data; each word arrives the cycle after its pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r    <= {PC_WIDTH{1'b0}};
         flags_r <= {FLAG_WIDTH{1'b0}};
      end else begin
         case (state_r)
            POP_HI: begin
               if (isRti_r) begin
                  flags_r <= mem_rdata[FLAG_WIDTH-1:0];
               end else begin
                  flags_r <= flags_r;
               end
            end
            POP_LO:  pc_r[PC_WIDTH-1:DATA_WIDTH] <= mem_rdata;
            WAIT_LO: pc_r[DATA_WIDTH-1:0]        <= mem_rdata;
            default: begin
               pc_r    <= pc_r;
               flags_r <= flags_r;
            end
         endcase
      end
   end

   assign pop_req     = popReq_r;
   assign busy        = busy_r;
   assign redirect    = redirect_r;
   assign flags_valid = flagsValid_r;
   assign pc_out      = pc_r;
   assign flags_out   = flags_r;

endmodule
